// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, drives the imem req/ack handshake and
// holds one fetched instruction for decode, with stall, redirect and halt.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        valid_out,
  output logic [31:0] instr,
  output logic [63:0] pc_out,
  output logic [63:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [11:0] funct12,
  output logic        halted,
  output logic [63:0] fetch_count
);

  typedef enum logic [1:0] {StReq, StWait, StSquash, StHalted} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic        halted_q, halted_d;
  logic [63:0] fetch_count_q, fetch_count_d;
  logic [63:0] squash_addr_q, squash_addr_d;

  logic halt_ev;
  logic redir_ev;
  logic accept;

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      instr_q       <= 32'h0000_0013;
      pc_out_q      <= 64'h0;
      halted_q      <= 1'b0;
      fetch_count_q <= 64'h0;
      squash_addr_q <= 64'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
      squash_addr_q <= squash_addr_d;
    end
  end

  // Handshake outputs and event decode; halt overrides a same-cycle redirect
  always_comb begin
    halt_ev   = valid_q && halt && !halted_q;
    redir_ev  = redirect && !halted_q && !halt_ev;
    imem_addr = (state_q == StSquash) ? squash_addr_q : pc_q;
    imem_req  = 1'b0;
    case (state_q)
      StReq:    imem_req = !halted_q && (!valid_q || !stall);
      StWait:   imem_req = 1'b1;
      StSquash: imem_req = 1'b1;
      default:  imem_req = 1'b0;
    endcase
    accept = imem_req && imem_ack && ((state_q == StReq) || (state_q == StWait)) &&
             !redir_ev && !halt_ev;
  end

  // Next-state: an unacked request that gets flushed must still be drained in StSquash
  always_comb begin
    state_d = state_q;
    case (state_q)
      StReq: begin
        if (imem_req && !imem_ack) state_d = (halt_ev || redir_ev) ? StSquash : StWait;
        else if (halt_ev)          state_d = StHalted;
      end
      StWait: begin
        if (imem_ack)                 state_d = halt_ev ? StHalted : StReq;
        else if (halt_ev || redir_ev) state_d = StSquash;
      end
      StSquash: begin
        if (imem_ack) state_d = halted_q ? StHalted : StReq;
      end
      default: state_d = StHalted;
    endcase
  end

  // Datapath next-state: pc, fetch/decode register, counters
  always_comb begin
    pc_d          = pc_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    fetch_count_d = fetch_count_q;
    halted_d      = halted_q || halt_ev;
    // Track the live request address so StSquash keeps presenting it
    squash_addr_d = (state_q == StSquash) ? squash_addr_q : imem_addr;
    if (redir_ev) begin
      pc_d = redirect_pc & ~64'h3;
    end else if (accept) begin
      pc_d          = pc_q + 64'd4;
      instr_d       = imem_rdata;
      pc_out_d      = pc_q;
      fetch_count_d = fetch_count_q + 64'd1;
    end
    if (halt_ev || redir_ev)       valid_d = 1'b0;
    else if (accept)               valid_d = 1'b1;
    else if (valid_q && !stall)    valid_d = 1'b0;
  end

  // Registered outputs and decode slices
  always_comb begin
    valid_out   = valid_q;
    instr       = instr_q;
    pc_out      = pc_out_q;
    pc_plus4    = pc_out_q + 64'd4;
    halted      = halted_q;
    fetch_count = fetch_count_q;
    opcode      = instr_q[6:0];
    rd          = instr_q[11:7];
    funct3      = instr_q[14:12];
    rs1         = instr_q[19:15];
    rs2         = instr_q[24:20];
    funct7      = instr_q[31:25];
    funct12     = instr_q[31:20];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect traffic
// against a model of the delivered pc stream and a variable-latency memory.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        valid_out;
  logic [31:0] instr;
  logic [63:0] pc_out;
  logic [63:0] pc_plus4;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] funct12;
  logic        halted;
  logic [63:0] fetch_count;

  fetch_unit #(.RESET_PC(64'h1000)) dut (
    .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .valid_out(valid_out), .instr(instr),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .funct7(funct7), .funct12(funct12), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Memory model state
  int          fixed_lat;
  int          mem_lat;
  int          mem_cnt;
  logic [63:0] held_addr;

  // Reference model: pc of the next instruction to be delivered, and count of
  // accepted instructions that have already left the register
  logic        model_en;
  logic [63:0] exp_pc;
  int          retired;

  function automatic logic [31:0] tag(input logic [63:0] a);
    return a[31:0] ^ 32'hC3A5_9E73;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic new_lat();
    mem_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
  endtask

  // One clock: called at a negedge with inputs applied, returns at the next negedge
  task automatic cycle();
    logic        pre_req, pre_ack, pre_valid, pre_stall, pre_redir;
    logic [63:0] pre_tgt, pre_addr;
    logic [31:0] w;
    #1;
    imem_ack   = imem_req && (mem_cnt >= mem_lat);
    imem_rdata = tag(imem_addr);
    if (imem_req && mem_cnt > 0) check("addr_stable", imem_addr, held_addr);
    if (model_en) begin
      check("fetch_count", fetch_count, 64'(retired + (valid_out ? 1 : 0)));
      if (valid_out) begin
        w = tag(exp_pc);
        check("pc_out", pc_out, exp_pc);
        check("instr", 64'(instr), 64'(w));
        check("pc_plus4", pc_plus4, exp_pc + 64'd4);
        check("fields", {opcode, rd, funct3, rs1, rs2, funct7, funct12},
              {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25], w[31:20]});
      end
    end
    pre_req   = imem_req;
    pre_ack   = imem_ack;
    pre_addr  = imem_addr;
    pre_valid = valid_out;
    pre_stall = stall;
    pre_redir = redirect;
    pre_tgt   = redirect_pc;
    @(posedge CLK);
    if (pre_req && pre_ack) begin
      mem_cnt = 0;
      new_lat();
    end else if (pre_req) begin
      if (mem_cnt == 0) held_addr = pre_addr;
      mem_cnt++;
    end else begin
      mem_cnt = 0;
    end
    if (model_en) begin
      if (pre_redir) begin
        if (pre_valid) retired++;
        exp_pc = pre_tgt & ~64'h3;
      end else if (pre_valid && !pre_stall) begin
        retired++;
        exp_pc = exp_pc + 64'd4;
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 64'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge CLK);
    RST = 1'b0;
    mem_cnt = 0;
    new_lat();
    exp_pc = 64'h1000;
    retired = 0;
    model_en = 1'b1;
  endtask

  initial begin
    // Reset values and first request
    fixed_lat = 0;
    do_reset();
    #1;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_instr", 64'(instr), 64'h13);
    check("rst_pc_out", pc_out, 64'h0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_req", 64'(imem_req), 64'd1);
    check("rst_addr", imem_addr, 64'h1000);

    // Zero-wait stream: 1000, 1004, 1008
    cycle(); check("zw0", pc_out, 64'h1000);
    cycle(); check("zw1", pc_out, 64'h1004);
    cycle(); check("zw2", pc_out, 64'h1008);
    check("zw_count", fetch_count, 64'd3);

    // Stall 4 cycles holding 1004
    do_reset();
    cycle(); cycle();
    stall = 1'b1;
    repeat (4) begin
      #1;
      check("stall_req", 64'(imem_req), 64'd0);
      check("stall_pc", pc_out, 64'h1004);
      cycle();
    end
    stall = 1'b0;
    cycle(); check("stall_rel", pc_out, 64'h1008);
    check("stall_count", fetch_count, 64'd3);

    // 3-cycle ack, redirect in second WAIT cycle
    fixed_lat = 3;
    do_reset();
    cycle(); cycle();
    redirect = 1'b1; redirect_pc = 64'h2002;
    cycle();
    redirect = 1'b0;
    #1;
    check("squash_addr", imem_addr, 64'h1000);
    check("squash_req", 64'(imem_req), 64'd1);
    cycle();
    #1;
    check("squash_valid", 64'(valid_out), 64'd0);
    check("refetch_addr", imem_addr, 64'h2000);
    for (int i = 0; i < 10 && !valid_out; i++) cycle();
    check("redir_valid", 64'(valid_out), 64'd1);
    check("redir_pc", pc_out, 64'h2000);
    check("redir_count", fetch_count, 64'd1);

    // Redirect and ack in the same cycle
    fixed_lat = 0;
    do_reset();
    cycle(); cycle();
    redirect = 1'b1; redirect_pc = 64'h3000;
    cycle();
    redirect = 1'b0;
    check("ra_valid", 64'(valid_out), 64'd0);
    check("ra_count", fetch_count, 64'd2);
    cycle(); check("ra_pc", pc_out, 64'h3000);

    // Halt together with redirect, no outstanding request
    model_en = 1'b0;
    stall = 1'b1; halt = 1'b1; redirect = 1'b1; redirect_pc = 64'h4000;
    cycle();
    stall = 1'b0; halt = 1'b0; redirect = 1'b0;
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_valid", 64'(valid_out), 64'd0);
    check("halt_pc", imem_addr, 64'h3004);
    repeat (20) begin
      #1;
      check("halt_req", 64'(imem_req), 64'd0);
      cycle();
    end
    check("halt_hold", 64'(halted), 64'd1);

    // Asynchronous reset while in WAIT
    do_reset();
    cycle();
    fixed_lat = 3;
    cycle();
    cycle();
    check("wait_count", fetch_count, 64'd2);
    #2;
    RST = 1'b1;
    #1;
    check("arst_valid", 64'(valid_out), 64'd0);
    check("arst_count", fetch_count, 64'd0);
    check("arst_instr", 64'(instr), 64'h13);
    check("arst_pc_out", pc_out, 64'h0);
    check("arst_addr", imem_addr, 64'h1000);
    check("arst_req", 64'(imem_req), 64'd1);
    fixed_lat = 0;
    do_reset();
    cycle(); check("restart_pc", pc_out, 64'h1000);

    // Random stall/redirect traffic with random memory latency
    fixed_lat = -1;
    do_reset();
    repeat (400) begin
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = {$urandom, $urandom};
      cycle();
      redirect = 1'b0;
    end
    stall = 1'b0;
    check("progress", 64'(retired > 40), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 64-bit RISC-V core. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It holds the returned instruction in a one-entry fetch/decode register and exposes the raw opcode/funct fields that the control unit decodes. It also absorbs downstream stalls, branch/jump redirects and halt.

## Interface
Parameters:
- RESET_PC, 64'h0, fetch address loaded on reset (bits [1:0] must be 0)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction memory request
- imem_addr  out  64  word address of request (= pc)
- imem_ack  in  1  request complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- stall  in  1  downstream cannot accept the held instruction this cycle
- redirect  in  1  branch/jump/jalr taken; flush and refetch
- redirect_pc  in  64  redirect target
- halt  in  1  control unit decoded halt on the held instruction
- valid_out  out  1  fetch/decode register holds a live instruction
- instr  out  32  held instruction
- pc_out  out  64  address of held instruction
- pc_plus4  out  64  pc_out + 4 (jal/jalr link value)
- opcode  out  7  instr[6:0]
- rd  out  5  instr[11:7]
- funct3  out  3  instr[14:12]
- rs1  out  5  instr[19:15]
- rs2  out  5  instr[24:20]
- funct7  out  7  instr[31:25]
- funct12  out  12  instr[31:20]
- halted  out  1  fetch permanently stopped
- fetch_count  out  64  instructions accepted into the fetch/decode register

## Operation
- The pc register holds the next fetch address. imem_addr = pc, combinationally.
- FSM states: REQ, WAIT, SQUASH, HALTED.
  - REQ: imem_req = !halted && (!valid_out || !stall).
    - req && ack in the same cycle: accept and stay in REQ.
    - req && !ack: go to WAIT.
  - WAIT: imem_req = 1 and imem_addr is held stable until ack. On ack: accept and go to REQ.
  - SQUASH: imem_req = 1 and imem_addr is held at the squashed address. On ack: discard the data; go to REQ, or to HALTED if halted is set.
  - HALTED: imem_req = 0, valid_out = 0. Only RST exits.
- Accept means: instr <= imem_rdata, pc_out <= pc, valid_out <= 1, pc <= pc + 4 (mod 2^64), fetch_count += 1.
- Consume: valid_out && !stall && no accept in that cycle gives valid_out <= 0.
- Requests are only issued when the register is empty or being consumed. An outstanding ack therefore never finds the register full.
- Redirect (only when !halted) has priority over stall and over accept:
  - pc <= {redirect_pc[63:2], 2'b00} and valid_out <= 0.
  - An ack arriving in the same cycle is discarded.
  - If in WAIT without ack, go to SQUASH.
  - If in SQUASH without ack, stay in SQUASH.
- Halt (valid_out && halt): set halted and valid_out <= 0.
  - halt && redirect in the same cycle: halt wins, the redirect is ignored, pc is unchanged.
  - If a request is outstanding without ack, go to SQUASH and then to HALTED.
  - Otherwise go to HALTED.
- Decoded fields are pure slices of instr. pc_plus4 = pc_out + 4.

## Timing
- Reset values:
  - pc = RESET_PC, state = REQ, valid_out = 0, instr = 32'h0000_0013 (nop), pc_out = 0, halted = 0, fetch_count = 0.
  - imem_req = 1 in the first cycle after reset deassertion.
- RST asserted mid-request: an immediate return to the reset values. Any in-flight ack is ignored; the memory must tolerate req dropping.
- Latency:
  - Zero-wait memory (ack same cycle as req): valid_out rises on the next edge; one instruction per cycle sustained.
  - N-cycle ack: valid_out rises on the edge after ack.
- Redirect to the first new instruction: the redirect edge clears valid_out. Next cycle, req is issued at the target. With zero-wait memory valid_out is 0 for exactly one cycle.
- stall held for k cycles with valid_out = 1: instr and pc_out are stable, imem_req = 0 (unless WAIT/SQUASH), pc is unchanged.

## Test plan
- Reset, RESET_PC = 64'h1000, zero-wait memory returning addr-tagged words -> pc_out = 1000, 1004, 1008 on consecutive cycles; fetch_count = 3 after 3 accepts.
- stall held 4 cycles with pc_out = 1004 -> instr/pc_out stable, imem_req = 0. Release -> 1008 follows next cycle with no loss or duplication.
- 3-cycle ack latency; redirect to 64'h2002 in the second WAIT cycle -> SQUASH entered, the returned word is discarded. Next req at 64'h2000; first valid pc_out = 2000.
- Redirect and ack in the same cycle -> data dropped, valid_out = 0 next cycle, fetch_count unchanged.
- halt with valid_out = 1 and no outstanding request -> halted = 1 and valid_out = 0 next cycle; imem_req stays 0 for 20 cycles. halt and redirect together -> pc is unchanged.
- RST pulsed while in WAIT -> all outputs return to the reset values asynchronously. Fetch restarts at RESET_PC after deassertion.
